// File: rtl/xc_malu_seq.sv
// xc_malu_seq: sequencer and step-register owner for the multi-cycle MALU
// datapath, plus the shared 32-bit packed adder used by that datapath.
// Build option: define XC_MALU_SEQ_PACKED_EN to let pw_16/pw_8/pw_4/pw_2
// split the adder carry chain into packed elements. Without it the adder is
// one 32-bit adder and all pw_* inputs are ignored.
module xc_malu_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    input  logic        flush,
    output logic        ready,
    output logic [63:0] result,
    output logic        busy,
    input  logic        pw_32,
    input  logic        pw_16,
    input  logic        pw_8,
    input  logic        pw_4,
    input  logic        pw_2,
    input  logic [63:0] init_acc,
    input  logic [31:0] init_arg_0,
    input  logic [31:0] init_arg_1,
    output logic [5:0]  count,
    output logic [63:0] acc,
    output logic [31:0] arg_0,
    output logic [31:0] arg_1,
    input  logic [63:0] n_acc,
    input  logic [31:0] n_arg_0,
    input  logic [31:0] n_arg_1,
    input  logic        dp_ready,
    input  logic [63:0] dp_result,
    input  logic [31:0] padd_lhs,
    input  logic [31:0] padd_rhs,
    input  logic        padd_sub,
    input  logic        padd_cin,
    input  logic        padd_cen,
    output logic [32:0] padd_cout,
    output logic [31:0] padd_result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] arg_0_q, arg_0_d;
    logic [31:0] arg_1_q, arg_1_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;

    logic [31:0] lsb_mask_s;
    logic [31:0] rhs_eff_s;
    logic        cin_s;
    logic        unused_pw_s;

    // pw_32 only documents the default width; fold it away explicitly
    assign unused_pw_s = ^{pw_32, pw_16, pw_8, pw_4, pw_2};

    // Sequencer next state: start, step, complete or abandon the operation
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        arg_0_d  = arg_0_q;
        arg_1_d  = arg_1_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (valid && !flush) begin
                    state_d = ST_RUN;
                    acc_d   = init_acc;
                    arg_0_d = init_arg_0;
                    arg_1_d = init_arg_1;
                    count_d = 6'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    count_d = 6'd0;
                end else if (dp_ready) begin
                    // Step registers hold so the final operands stay visible
                    state_d  = ST_DONE;
                    result_d = dp_result;
                end else begin
                    acc_d   = n_acc;
                    arg_0_d = n_arg_0;
                    arg_1_d = n_arg_1;
                    if (count_q != 6'd63) begin
                        count_d = count_q + 6'd1;
                    end else begin
                        count_d = count_q;
                    end
                end
            end
            ST_DONE: begin
                if (valid && !flush) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = 6'd0;
            end
        endcase
        // Status outputs are registered from the state being entered
        ready_d = (state_d == ST_DONE);
        busy_d  = (state_d == ST_RUN);
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= 6'd0;
            acc_q    <= 64'd0;
            arg_0_q  <= 32'd0;
            arg_1_q  <= 32'd0;
            result_q <= 64'd0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            arg_0_q  <= arg_0_d;
            arg_1_q  <= arg_1_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign count  = count_q;
    assign acc    = acc_q;
    assign arg_0  = arg_0_q;
    assign arg_1  = arg_1_q;
    assign result = result_q;
    assign ready  = ready_q;
    assign busy   = busy_q;

`ifdef XC_MALU_SEQ_PACKED_EN
    // Element LSB positions for the selected packed width (32 if none set)
    always_comb begin
        if (pw_16) begin
            lsb_mask_s = 32'h0001_0001;
        end else if (pw_8) begin
            lsb_mask_s = 32'h0101_0101;
        end else if (pw_4) begin
            lsb_mask_s = 32'h1111_1111;
        end else if (pw_2) begin
            lsb_mask_s = 32'h5555_5555;
        end else begin
            lsb_mask_s = 32'h0000_0001;
        end
    end
`else
    assign lsb_mask_s = 32'h0000_0001;
`endif

    // Packed ripple adder: element LSBs take padd_sub as carry-in, interior
    // carries are gated by padd_cen, carry-outs are produced at every bit
    always_comb begin
        rhs_eff_s    = padd_rhs ^ {32{padd_sub}};
        padd_cout    = 33'd0;
        padd_result  = 32'd0;
        cin_s        = 1'b0;
        padd_cout[0] = padd_cin | padd_sub;
        for (int i = 0; i < 32; i++) begin
            if (i == 0) begin
                cin_s = padd_cout[0];
            end else if (lsb_mask_s[i]) begin
                cin_s = padd_sub;
            end else begin
                cin_s = padd_cen & padd_cout[i];
            end
            padd_result[i] = padd_lhs[i] ^ rhs_eff_s[i] ^ cin_s;
            padd_cout[i+1] = (padd_lhs[i] & rhs_eff_s[i]) |
                             (padd_lhs[i] & cin_s) |
                             (rhs_eff_s[i] & cin_s);
        end
    end

endmodule

// File: tb/tb_xc_malu_seq.sv
// Self-checking bench for xc_malu_seq: a transaction-level model of the
// sequencer and an element-arithmetic model of the packed adder, compared
// against the DUT on every falling edge, plus hand-computed literal checks.
module tb_xc_malu_seq;

    logic        clock, reset, valid, flush;
    logic        ready, busy;
    logic [63:0] result;
    logic        pw_32, pw_16, pw_8, pw_4, pw_2;
    logic [63:0] init_acc;
    logic [31:0] init_arg_0, init_arg_1;
    logic [5:0]  count;
    logic [63:0] acc;
    logic [31:0] arg_0, arg_1;
    logic [63:0] n_acc;
    logic [31:0] n_arg_0, n_arg_1;
    logic        dp_ready;
    logic [63:0] dp_result;
    logic [31:0] padd_lhs, padd_rhs;
    logic        padd_sub, padd_cin, padd_cen;
    logic [32:0] padd_cout;
    logic [31:0] padd_result;

    // datapath stand-in configuration
    logic [5:0]  k_tgt;
    logic [63:0] dp_salt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit prand_en = 1'b0;

    xc_malu_seq dut (
        .clock(clock), .reset(reset), .valid(valid), .flush(flush),
        .ready(ready), .result(result), .busy(busy),
        .pw_32(pw_32), .pw_16(pw_16), .pw_8(pw_8), .pw_4(pw_4), .pw_2(pw_2),
        .init_acc(init_acc), .init_arg_0(init_arg_0), .init_arg_1(init_arg_1),
        .count(count), .acc(acc), .arg_0(arg_0), .arg_1(arg_1),
        .n_acc(n_acc), .n_arg_0(n_arg_0), .n_arg_1(n_arg_1),
        .dp_ready(dp_ready), .dp_result(dp_result),
        .padd_lhs(padd_lhs), .padd_rhs(padd_rhs), .padd_sub(padd_sub),
        .padd_cin(padd_cin), .padd_cen(padd_cen),
        .padd_cout(padd_cout), .padd_result(padd_result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Simple datapath: acc counts up, arg_0 steps by 3, arg_1 rotates left,
    // completion when count reaches k_tgt, result salted from acc
    always_comb begin
        n_acc     = acc + 64'd1;
        n_arg_0   = arg_0 + 32'd3;
        n_arg_1   = {arg_1[30:0], arg_1[31]};
        dp_ready  = (count == k_tgt);
        dp_result = acc ^ dp_salt;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference packed adder: per-element arithmetic with carry-in at the
    // element LSB; cm/cv give the carry-out bits the model pins down
    function automatic logic [31:0] padd_ref(input logic [31:0] l, input logic [31:0] r,
                                             input logic s, input logic ci, input logic ce,
                                             input int w,
                                             output logic [32:0] cm, output logic [32:0] cv);
        logic [31:0] rr, res;
        longint unsigned m, a, b, c, sum;
        int lo;
        rr = r ^ {32{s}};
        res = 32'd0; cm = 33'd0; cv = 33'd0;
        cm[0] = 1'b1; cv[0] = ci | s;
        m = (64'd1 << w) - 64'd1;
        for (int e = 0; e < 32 / w; e++) begin
            lo = e * w;
            a = (64'(l) >> lo) & m;
            b = (64'(rr) >> lo) & m;
            c = (e == 0) ? 64'(ci | s) : 64'(s);
            if (ce) begin
                sum = a + b + c;
                res = res | 32'((sum & m) << lo);
                cm[lo + w] = 1'b1;
                cv[lo + w] = 1'((sum >> w) & 64'd1);
            end else begin
                res = res | 32'(((a ^ b ^ c) & m) << lo);
            end
        end
        return res;
    endfunction

    function automatic int pw_width();
`ifdef XC_MALU_SEQ_PACKED_EN
        if (pw_16) return 16;
        else if (pw_8) return 8;
        else if (pw_4) return 4;
        else if (pw_2) return 2;
        else return 32;
`else
        return 32;
`endif
    endfunction

    // Transaction model of the sequencer, advanced on the same edges
    int          m_mode;   // 0 idle, 1 running, 2 done
    int          m_count;
    logic [63:0] m_acc, m_result;
    logic [31:0] m_a0, m_a1;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_count = 0; m_acc = 64'd0; m_a0 = 32'd0; m_a1 = 32'd0;
            m_result = 64'd0;
        end else if (m_mode == 0) begin
            if (valid && !flush) begin
                m_mode = 1; m_count = 0;
                m_acc = init_acc; m_a0 = init_arg_0; m_a1 = init_arg_1;
            end
        end else if (m_mode == 1) begin
            if (flush) begin
                m_mode = 0; m_count = 0;
            end else if (m_count == int'(k_tgt)) begin
                m_result = m_acc ^ dp_salt;
                m_mode = 2;
            end else begin
                m_acc = m_acc + 64'd1;
                m_a0 = m_a0 + 32'd3;
                m_a1 = (m_a1 << 1) | (m_a1 >> 31);
                m_count = (m_count < 63) ? m_count + 1 : 63;
            end
        end else begin
            if (!(valid && !flush)) m_mode = 0;
        end
    end

    // Compare DUT against both models on every falling edge
    always @(negedge clock) begin
        logic [31:0] pr;
        logic [32:0] cm, cv;
        if (cmp_en && !reset) begin
            chk("ready", 64'(ready), 64'(m_mode == 2));
            chk("busy", 64'(busy), 64'(m_mode == 1));
            chk("count", 64'(count), 64'(m_count));
            chk("acc", acc, m_acc);
            chk("arg_0", 64'(arg_0), 64'(m_a0));
            chk("arg_1", 64'(arg_1), 64'(m_a1));
            chk("result", result, m_result);
            pr = padd_ref(padd_lhs, padd_rhs, padd_sub, padd_cin, padd_cen, pw_width(), cm, cv);
            chk("padd_result", 64'(padd_result), 64'(pr));
            chk("padd_cout", 64'(padd_cout & cm), 64'(cv & cm));
        end
    end

    // Random adder operands each cycle once enabled
    initial begin
        int sel;
        forever begin
            @(posedge clock);
            #2;
            if (prand_en) begin
                padd_lhs = $urandom; padd_rhs = $urandom;
                padd_sub = 1'($urandom); padd_cin = 1'($urandom);
                padd_cen = ($urandom_range(0, 3) != 0);
                sel = $urandom_range(0, 5);
                pw_32 = (sel == 0); pw_16 = (sel == 1); pw_8 = (sel == 2);
                pw_4 = (sel == 3); pw_2 = (sel == 4);
            end
        end
    end

    task automatic set_pw(input int w);
        pw_32 = (w == 32); pw_16 = (w == 16); pw_8 = (w == 8);
        pw_4 = (w == 4); pw_2 = (w == 2);
    endtask

    task automatic wait_count(input logic [5:0] c);
        int n;
        n = 0;
        while (!(busy && count == c) && n < 80) begin
            @(posedge clock); #1; n++;
        end
        chk("wait_count_bound", 64'(n < 80), 64'd1);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 80) begin
            @(posedge clock); #1; n++;
        end
        chk("wait_ready_bound", 64'(n < 80), 64'd1);
    endtask

    initial begin
        int cyc;
        reset = 1'b1; valid = 1'b0; flush = 1'b0;
        set_pw(32);
        init_acc = 64'd0; init_arg_0 = 32'd0; init_arg_1 = 32'd0;
        padd_lhs = 32'd0; padd_rhs = 32'd0; padd_sub = 1'b0; padd_cin = 1'b0; padd_cen = 1'b1;
        k_tgt = 6'd32; dp_salt = 64'h1214;
        #1;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_acc", acc, 64'd0);
        chk("rst_result", result, 64'd0);

        // hand-computed adder vectors
        padd_lhs = 32'hFFFF_FFFF; padd_rhs = 32'h0000_0001; #1;
        chk("add32_res", 64'(padd_result), 64'h0);
        chk("add32_cout32", 64'(padd_cout[32]), 64'd1);
        set_pw(8); padd_lhs = 32'h00FF_00FF; padd_rhs = 32'h0001_0001; #1;
`ifdef XC_MALU_SEQ_PACKED_EN
        chk("add8_res", 64'(padd_result), 64'h0);
        chk("add8_cout8", 64'(padd_cout[8]), 64'd1);
        chk("add8_cout24", 64'(padd_cout[24]), 64'd1);
`else
        chk("add8_res", 64'(padd_result), 64'h0100_0100);
`endif
        set_pw(16); padd_lhs = 32'h0005_0003; padd_rhs = 32'h0001_0004; padd_sub = 1'b1; #1;
`ifdef XC_MALU_SEQ_PACKED_EN
        chk("sub16_res", 64'(padd_result), 64'h0004_FFFF);
`else
        chk("sub32_res", 64'(padd_result), 64'h0003_FFFF);
`endif
        set_pw(32); padd_sub = 1'b0; padd_cen = 1'b0;
        padd_lhs = 32'hF0F0_F0F0; padd_rhs = 32'hFFFF_0000; #1;
        chk("clmul_xor_res", 64'(padd_result), 64'h0F0F_F0F0);
        padd_cen = 1'b1;

        @(posedge clock); #2;
        reset = 1'b0; cmp_en = 1'b1; prand_en = 1'b1;

        // stepping: complete at count 32 with result 0x1234
        init_acc = 64'd0; init_arg_0 = 32'h1111_0000; init_arg_1 = 32'h8000_0001;
        k_tgt = 6'd32; dp_salt = 64'h1214;
        valid = 1'b1;
        cyc = 0;
        while (!ready && cyc < 60) begin
            @(posedge clock); #1; cyc++;
        end
        chk("step_latency", 64'(cyc), 64'd34);
        chk("step_result", result, 64'h1234);
        chk("step_acc", acc, 64'd32);
        repeat (3) begin
            @(posedge clock); #1;
            chk("done_hold", 64'(ready), 64'd1);
        end
        #1; valid = 1'b0;
        @(posedge clock); #1;
        chk("done_exit_ready", 64'(ready), 64'd0);
        chk("done_exit_busy", 64'(busy), 64'd0);

        // flush at count 10
        #1; k_tgt = 6'd20; init_acc = 64'd100; valid = 1'b1;
        wait_count(6'd10);
        #1; flush = 1'b1; valid = 1'b0;
        @(posedge clock); #1;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_result", result, 64'h1234);
        #1; flush = 1'b0;
        repeat (4) begin
            @(posedge clock); #1;
            chk("flush_no_ready", 64'(ready), 64'd0);
        end

        // flush coincident with dp_ready
        #1; k_tgt = 6'd5; init_acc = 64'd7; valid = 1'b1;
        wait_count(6'd5);
        #1; flush = 1'b1; valid = 1'b0;
        @(posedge clock); #1;
        chk("flush_dp_busy", 64'(busy), 64'd0);
        chk("flush_dp_ready", 64'(ready), 64'd0);
        chk("flush_dp_result", result, 64'h1234);
        #1; flush = 1'b0;
        @(posedge clock); #2;

        // asynchronous reset mid-run, then restart from init values
        k_tgt = 6'd30; init_acc = 64'hA5A5_0000_0000_0042; valid = 1'b1;
        wait_count(6'd7);
        #2; reset = 1'b1; #1;
        chk("arst_ready", 64'(ready), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_acc", acc, 64'd0);
        chk("arst_result", result, 64'd0);
        @(negedge clock); #1; reset = 1'b0;
        @(posedge clock); #1;
        chk("restart_busy", 64'(busy), 64'd1);
        chk("restart_count", 64'(count), 64'd0);
        chk("restart_acc", acc, 64'hA5A5_0000_0000_0042);
        wait_ready();
        #1; valid = 1'b0;
        @(posedge clock); #2;

        // randomized operations
        for (int t = 0; t < 30; t++) begin
            int mode;
            logic [5:0] fa;
            init_acc = {$urandom, $urandom}; init_arg_0 = $urandom; init_arg_1 = $urandom;
            dp_salt = {$urandom, $urandom};
            k_tgt = 6'($urandom_range(0, 34));
            mode = $urandom_range(0, 3);
            valid = 1'b1;
            if (mode == 0) begin
                fa = 6'($urandom_range(0, int'(k_tgt)));
                wait_count(fa);
                #1; flush = 1'b1; valid = 1'b0;
                @(posedge clock); #2; flush = 1'b0;
            end else begin
                wait_ready();
                repeat ($urandom_range(0, 3)) @(posedge clock);
                #2;
                if (mode == 1) begin
                    flush = 1'b1;
                    @(posedge clock); #2;
                    flush = 1'b0;
                end
                valid = 1'b0;
                @(posedge clock); #2;
            end
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #2;
        end

        @(posedge clock); #2;
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xc_malu_seq.md
# xc_malu_seq

Sequencer and state owner for the multi-cycle MALU datapath. It accepts a single-operation handshake from the pipeline and holds the `count`, `acc`, `arg_0` and `arg_1` step registers. Each cycle it presents those registers to the combinational mul/div/rem/pmul datapath and commits that datapath's next-state outputs, until the datapath reports ready. It also implements the shared 32-bit packed adder that the datapath drives through the `padd_*` interface.

## Interface
Parameters: none.

Ports:
- `clock` in 1 — sole clock, rising edge.
- `reset` in 1 — asynchronous, active-high reset.
- `valid` in 1 — operation request; held high by the pipeline until the result is consumed.
- `flush` in 1 — abandon the current operation.
- `ready` out 1 — result valid.
- `result` out 64 — registered final result.
- `busy` out 1 — high in RUN.
- `pw_32`, `pw_16`, `pw_8`, `pw_4`, `pw_2` in 1 each — packed element width, one-hot, stable while `valid` is high.
- `init_acc` in 64, `init_arg_0` in 32, `init_arg_1` in 32 — start values supplied by the datapath.
- `count` out 6, `acc` out 64, `arg_0` out 32, `arg_1` out 32 — current step registers.
- `n_acc` in 64, `n_arg_0` in 32, `n_arg_1` in 32 — next step values from the datapath.
- `dp_ready` in 1, `dp_result` in 64 — datapath completion flag and final value, both computed from the current registers.
- `padd_lhs` in 32, `padd_rhs` in 32 — packed adder operands.
- `padd_sub` in 1, `padd_cin` in 1, `padd_cen` in 1 — subtract, bit-0 carry-in, carry enable.
- `padd_cout` out 33, `padd_result` out 32 — combinational packed adder outputs.

## Operation
States: IDLE, RUN, DONE.

**Reset.** State is IDLE. `count`, `acc`, `arg_0`, `arg_1`, `result` and `ready` are all 0, and `busy` is 0.

**IDLE.**
- If `valid && !flush`: load `acc`, `arg_0` and `arg_1` from the `init_*` inputs, set `count` to 0, and go to RUN.

**RUN.** Conditions are evaluated in this order:
- If `flush`: go to IDLE and set `count` to 0.
- Else if `dp_ready`: set `result <= dp_result` and go to DONE. The step registers hold.
- Else: set `acc <= n_acc`, `arg_0 <= n_arg_0`, `arg_1 <= n_arg_1`, and increment `count`. `count` saturates at 63 and stepping continues. The datapath must assert `dp_ready` by `count` 34.

**DONE.**
- `ready` is high.
- Stay in DONE while `valid && !flush`.
- Otherwise go to IDLE. `result` holds its value until the next completion.
- Back-to-back operations require `valid` to be low for at least one cycle.

**Packed adder** (combinational).
- Element boundaries at 16, 8, 4 or 2 bits per the selected `pw_*`.
- If no `pw_*` is set, treat the width as 32.
- Effective rhs is `padd_rhs ^ {32{padd_sub}}`.
- `padd_cout[0]` is `padd_cin | padd_sub`.
- Carry into bit i (i > 0):
  - `padd_sub` if bit i is an element LSB;
  - otherwise `padd_cen & padd_cout[i]`.
- Carry into bit 0 is `padd_cout[0]`.
- `padd_result[i] = lhs[i] ^ rhs_eff[i] ^ cin_i`.
- `padd_cout[i+1]` is the full-adder carry out of bit i. It is computed even at element MSBs.
- With `padd_cen = 0`, interior carries are suppressed, giving a carryless XOR per element.

## Timing
- Latency from `valid` sampled in IDLE to `ready` is N+2 cycles, where N is the number of RUN steps before `dp_ready`.
- `dp_ready` asserted at `count` = k gives `ready` k+2 cycles after the start edge.
- `ready` and `result` are registered; there is no combinational path from `valid` to `ready`.
- `flush` takes effect at the next edge from any state and has priority over `valid` and `dp_ready`.
- A simultaneous `flush` and `dp_ready` does not update `result`.
- Reset asserted mid-operation forces all outputs to their reset values immediately.
- The `padd_*` path is purely combinational within one cycle.

## Configuration
- `XC_MALU_SEQ_PACKED_EN` defined: `pw_16`, `pw_8`, `pw_4` and `pw_2` split the adder carry chain as described above.
- `XC_MALU_SEQ_PACKED_EN` undefined:
  - all `pw_*` inputs are ignored;
  - the adder is a single 32-bit adder, with element LSB at bit 0 only;
  - `padd_cen` still gates interior carries.

## Test plan
- **Adder, 32-bit:** `pw_32`, lhs=FFFFFFFF, rhs=00000001, sub=0, cin=0, cen=1 -> result=00000000, `padd_cout[32]`=1.
- **Adder, packed 8-bit:** `pw_8`, lhs=00FF00FF, rhs=00010001 -> result=00000000, `padd_cout[8]`=`padd_cout[24]`=1, bit 8 unaffected. With the macro undefined -> result=01000100.
- **Packed subtract and carryless:** `pw_16`, lhs=00050003, rhs=00010004, sub=1 -> 0004FFFF. `pw_32`, cen=0, lhs=F0F0F0F0, rhs=FFFF0000 -> 0F0FF0F0.
- **Stepping:** the datapath model sets `n_acc=acc+1` and raises `dp_ready` at `count`=32, with `dp_result`=0x1234 -> `ready` rises 34 cycles after start, `result`=0x1234, `acc`=32. `ready` holds until `valid` drops, then IDLE.
- **Flush:** `flush` at `count`=10 in RUN -> next cycle IDLE, `count`=0, `ready` never asserts, `result` unchanged. `flush` coincident with `dp_ready` -> IDLE, `result` unchanged.
- **Reset:** `reset` asserted mid-RUN between clock edges -> `ready`, `busy`, `count`, `acc` and `result` are 0 immediately. After release with `valid` high, the operation restarts from the `init_*` values.
